// File: rtl/pmem_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_burst_responder
//  Purpose  : Physical-memory model behind the cache line interface. It
//             accepts one 128-bit line read or write at a time and holds it
//             for LATENCY cycles. It then answers with a single-cycle
//             pmem_resp pulse, with read data for reads.
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_burst_responder #(
    parameter int LATENCY = 4,      // 1..255 cycles, acceptance to pmem_resp
    parameter int LINES   = 256     // power of two
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       rdata_q, rdata_d;

    logic               w_mem_we;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_unused_addr;

    // Backing store; deliberately left uncleared by reset.
    logic [127:0]       mem [LINES];

    // Higher address bits alias; the low nibble is the byte offset in a line.
    assign w_req_idx     = pmem_address[4+IDX_W-1:4];
    assign w_unused_addr = ^pmem_address;

    assign pmem_resp  = (state_q == ST_RESP);
    assign pmem_rdata = rdata_q;
    assign busy       = (state_q != ST_IDLE);

    // Next-state, request latching and read-data capture on entry to RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        w_mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    // A simultaneous read+write is a protocol error; the write wins.
                    is_wr_d = pmem_write;
                    idx_d   = w_req_idx;
                    wdata_d = pmem_wdata;
                    if (LATENCY == 1) begin
                        // No wait phase: the line is fetched straight from the request.
                        state_d = ST_RESP;
                        if (!pmem_write) begin
                            rdata_d = mem[w_req_idx];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 8'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                // The counter holds the WAIT cycles still to go, this one included.
                cnt_d = cnt_q - 8'd1;
                if (cnt_d == 8'd0) begin
                    state_d = ST_RESP;
                    if (!is_wr_q) begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            ST_RESP: begin
                w_mem_we = is_wr_q;
                state_d  = ST_TURN;
            end
            ST_TURN: begin
                // Requests are ignored here so the initiator can drop its request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers; reset aborts any in-flight transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit a write at the edge that ends RESP, unless reset is active at that edge.
    always_ff @(posedge clk) begin
        if (reset_n && w_mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
`default_nettype wire
